// File: rtl/gcd_stream_engine.sv
// Streaming binary-GCD (Stein) engine: one shift/subtract step per clock,
// valid/ready on both sides, returns the GCD, the RUN cycle count and a zero-operand flag.
module gcd_stream_engine #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(2*WIDTH)+1,
  localparam int K_W   = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd,
  output logic [CNT_W-1:0] cycles,
  output logic             zero_in
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a, a_n, b, b_n;
  logic [K_W-1:0]   k, k_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [WIDTH-1:0] gcd_n;
  logic [CNT_W-1:0] cycles_n;
  logic             zero_n;

  assign cnt_inc = cnt + CNT_W'(1);

  // Result registers only change on DONE entry, so outputs hold through the next RUN.
  always_comb begin
    state_n  = state;
    a_n      = a;
    b_n      = b;
    k_n      = k;
    cnt_n    = cnt;
    gcd_n    = gcd;
    cycles_n = cycles;
    zero_n   = zero_in;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          a_n   = a_in;
          b_n   = b_in;
          k_n   = '0;
          cnt_n = '0;
          if (a_in == '0 || b_in == '0) begin
            gcd_n    = a_in | b_in;
            cycles_n = '0;
            zero_n   = 1'b1;
            state_n  = S_DONE;
          end else begin
            state_n = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_n = cnt_inc;
        if (a == b) begin
          gcd_n    = a << k;
          cycles_n = cnt_inc;
          zero_n   = 1'b0;
          state_n  = S_DONE;
        end else if (!a[0] && !b[0]) begin
          a_n = a >> 1;
          b_n = b >> 1;
          k_n = k + K_W'(1);
        end else if (!a[0]) begin
          a_n = a >> 1;
        end else if (!b[0]) begin
          b_n = b >> 1;
        end else if (a > b) begin
          a_n = (a - b) >> 1;
        end else begin
          b_n = (b - a) >> 1;
        end
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      a       <= '0;
      b       <= '0;
      k       <= '0;
      cnt     <= '0;
      gcd     <= '0;
      cycles  <= '0;
      zero_in <= 1'b0;
    end else begin
      state   <= state_n;
      a       <= a_n;
      b       <= b_n;
      k       <= k_n;
      cnt     <= cnt_n;
      gcd     <= gcd_n;
      cycles  <= cycles_n;
      zero_in <= zero_n;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_gcd_stream_engine.sv
// Self-checking bench for gcd_stream_engine: directed cases plus random regression
// at WIDTH=8 and WIDTH=16 against a Euclid / step-count reference model.
module tb_gcd_stream_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        iv8 = 0, rdy8, ov8, ordy8 = 0, z8;
  logic [7:0]  a8 = 0, b8 = 0, g8;
  logic [4:0]  c8;
  logic        iv16 = 0, rdy16, ov16, ordy16 = 0, z16;
  logic [15:0] a16 = 0, b16 = 0, g16;
  logic [5:0]  c16;

  int n_checks = 0;
  int n_fail = 0;

  gcd_stream_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(rdy8), .a_in(a8), .b_in(b8),
    .out_valid(ov8), .out_ready(ordy8), .gcd(g8), .cycles(c8), .zero_in(z8));

  gcd_stream_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(rdy16), .a_in(a16), .b_in(b16),
    .out_valid(ov16), .out_ready(ordy16), .gcd(g16), .cycles(c16), .zero_in(z16));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned gcd_ref(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Number of RUN clocks taken by Stein's rule sequence, the terminating compare included.
  function automatic int unsigned steps_ref(input int unsigned x, input int unsigned y);
    int unsigned n = 0;
    if (x == 0 || y == 0) return 0;
    while (1) begin
      n++;
      if (x == y) break;
      if (x % 2 == 0 && y % 2 == 0) begin x /= 2; y /= 2; end
      else if (x % 2 == 0) x /= 2;
      else if (y % 2 == 0) y /= 2;
      else if (x > y) x = (x - y) / 2;
      else y = (y - x) / 2;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w16, input int unsigned a, input int unsigned b);
    if (w16) begin iv16 = 1; a16 = a[15:0]; b16 = b[15:0]; end
    else     begin iv8 = 1;  a8 = a[7:0];   b8 = b[7:0];   end
  endtask

  // One full transaction; leaves the result displayed (out_valid high) when hold=1.
  task automatic xact(input bit w16, input int unsigned a, input int unsigned b,
                      input string tag, input bit hold);
    int unsigned eg, ec;
    int n;
    eg = gcd_ref(a, b);
    ec = steps_ref(a, b);
    n = 0;
    while (!(w16 ? rdy16 : rdy8) && n < 100) begin step(); n++; end
    check({tag, ".ready_wait"}, (n < 100), 1);
    drive(w16, a, b);
    step();
    iv8 = 0; iv16 = 0;
    check({tag, ".in_ready_low"}, w16 ? rdy16 : rdy8, 0);
    n = 0;
    while (!(w16 ? ov16 : ov8) && n < 100) begin
      if (w16) begin a16 = ~a16; b16 = b16 + 1; end else begin a8 = ~a8; b8 = b8 + 1; end
      step();
      n++;
    end
    check({tag, ".latency"}, n, ec);
    check({tag, ".gcd"}, w16 ? g16 : g8, eg);
    check({tag, ".cycles"}, w16 ? c16 : c8, ec);
    check({tag, ".zero_in"}, w16 ? z16 : z8, (a == 0 || b == 0));
    check({tag, ".cycles_bound"}, ((w16 ? c16 : c8) <= (w16 ? 32 : 16)), 1);
    if (!hold) begin
      if (w16) ordy16 = 1; else ordy8 = 1;
      step();
      ordy8 = 0; ordy16 = 0;
      check({tag, ".out_valid_drop"}, w16 ? ov16 : ov8, 0);
      check({tag, ".in_ready_back"}, w16 ? rdy16 : rdy8, 1);
      check({tag, ".gcd_kept"}, w16 ? g16 : g8, eg);
    end
  endtask

  initial begin
    int unsigned ra, rb;
    logic [7:0] g_hold;
    logic [4:0] c_hold;

    #2;
    check("rst.in_ready", rdy8, 1);
    check("rst.out_valid", ov8, 0);
    check("rst.gcd", g8, 0);
    check("rst.cycles", c8, 0);
    check("rst.zero_in", z8, 0);
    @(negedge clk);
    reset = 0;
    step();

    // (48,18): intermediate trace (24,9,1)->(3,3,1) gives 6 RUN cycles, gcd 6
    xact(0, 48, 18, "d48_18", 0);
    check("d48_18.const_cycles", c8, 6);
    xact(0, 17, 13, "d17_13", 0);
    check("d17_13.const_gcd", g8, 1);
    xact(0, 255, 255, "d255", 0);
    check("d255.const_cycles", c8, 1);
    xact(0, 0, 25, "z0_25", 0);
    check("z0_25.const_gcd", g8, 25);
    xact(0, 0, 0, "z0_0", 0);
    check("z0_0.zero_in", z8, 1);
    xact(0, 25, 0, "z25_0", 0);

    // Backpressure: hold the result and offer a new pair that must be ignored.
    xact(0, 48, 18, "bp", 1);
    g_hold = g8;
    c_hold = c8;
    iv8 = 1; a8 = 3; b8 = 7;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp.out_valid_held", ov8, 1);
      check("bp.in_ready_low", rdy8, 0);
      check("bp.gcd_stable", g8, 6);
      check("bp.cycles_stable", c8, 6);
    end
    iv8 = 0;
    ordy8 = 1;
    step();
    ordy8 = 0;
    check("bp.released", rdy8, 1);
    check("bp.gcd_after", g8, g_hold);
    check("bp.cycles_after", c8, c_hold);
    xact(0, 128, 64, "d128_64", 0);
    check("d128_64.const_gcd", g8, 64);

    // Async reset in the middle of RUN.
    drive(0, 200, 150);
    step();
    iv8 = 0;
    step();
    step();
    check("mid.in_run", {rdy8, ov8}, 2'b00);
    reset = 1;
    #1;
    check("mid.in_ready", rdy8, 1);
    check("mid.out_valid", ov8, 0);
    check("mid.gcd", g8, 0);
    check("mid.cycles", c8, 0);
    check("mid.zero_in", z8, 0);
    @(negedge clk);
    reset = 0;
    step();
    check("mid.still_idle", ov8, 0);
    xact(0, 200, 150, "d200_150", 0);
    check("d200_150.const_gcd", g8, 50);

    for (int i = 0; i < 600; i++) begin
      ra = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(0, 255);
      rb = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(0, 255);
      xact(0, ra, rb, "rnd8", 0);
    end
    xact(1, 65535, 65535, "w16_max", 0);
    xact(1, 32768, 49152, "w16_pow2", 0);
    for (int i = 0; i < 600; i++) begin
      ra = ($urandom_range(0, 31) == 0) ? 0 : $urandom_range(0, 65535);
      rb = ($urandom_range(0, 31) == 0) ? 0 : $urandom_range(0, 65535);
      xact(1, ra, rb, "rnd16", 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
